// File: rtl/audio_sched_pkg.sv
// Shared constants, sample type and saturating adder for the I2S sample scheduler.
package audio_sched_pkg;

    localparam int FRAME_LEN     = 512;
    localparam int SCK_SHIFT_POS = 15;
    localparam int MCLK_BIT      = 1;
    localparam int SCK_BIT       = 3;
    localparam int LRCK_BIT      = 8;

    typedef struct packed {
        logic [15:0] left;
        logic [15:0] right;
    } stereo_sample_t;

    // Signed 16-bit add clamped to the representable range.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {a[15], a} + {b[15], b};
        if (sum[16:15] == 2'b01)
            return 16'h7FFF;
        else if (sum[16:15] == 2'b10)
            return 16'h8000;
        else
            return sum[15:0];
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request arbiter: round-robin or fixed priority to req[0], with last-grant memory.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       rr_mode,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic last_grant;

    always_comb begin
        gnt = req;
        if (req == 2'b11)
            gnt = (rr_mode && !last_grant) ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= 1'b1;
        else if (update)
            last_grant <= gnt[1];
    end

endmodule

// File: rtl/i2s_sample_scheduler.sv
// I2S frame scheduler: clock generation, one-sample-per-frame holding and MSB-first serializer.
// Optional build macro AUDIO_MIX_EN: simultaneous requests are summed with per-channel saturation.
module i2s_sample_scheduler
    import audio_sched_pkg::*;
#(
    parameter bit RR_EN_DEFAULT = 1'b1,
    parameter bit UNDERRUN_HOLD = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        src0_valid,
    input  logic [31:0] src0_data,
    input  logic        src1_valid,
    input  logic [31:0] src1_data,
    output logic        src0_ready,
    output logic        src1_ready,
    output logic        audio_mclk,
    output logic        audio_sck,
    output logic        audio_lrck,
    output logic        audio_sdin,
    output logic        frame_start,
    output logic        underrun,
    output logic [15:0] underrun_cnt
);

    logic [8:0]     cnt;
    logic           hold_full;
    stereo_sample_t hold;
    stereo_sample_t next_hold;
    logic [31:0]    sr;
    logic [31:0]    last_tx;
    logic           boundary;
    logic           shift_pos;
    logic           open;
    logic           accept;
    logic [1:0]     gnt;
    logic           arb_update;

    assign boundary  = (cnt == 9'(FRAME_LEN - 1));
    assign shift_pos = (cnt[3:0] == 4'(SCK_SHIFT_POS));
    // Ready is withheld at the boundary so an accept never races the hold->sr transfer.
    assign open      = en && !hold_full && !boundary;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .rr_mode (RR_EN_DEFAULT),
        .req     ({src1_valid, src0_valid}),
        .update  (arb_update),
        .gnt     (gnt)
    );

`ifdef AUDIO_MIX_EN
    logic           mix;
    stereo_sample_t mixed;

    assign mix        = src0_valid && src1_valid;
    assign mixed      = {sat_add16(src0_data[31:16], src1_data[31:16]),
                         sat_add16(src0_data[15:0],  src1_data[15:0])};
    assign src0_ready = open && (mix || gnt[0]);
    assign src1_ready = open && (mix || gnt[1]);
    assign arb_update = open && !mix && (gnt != 2'b00);
    assign next_hold  = mix ? mixed : (gnt[1] ? src1_data : src0_data);
`else
    assign src0_ready = open && gnt[0];
    assign src1_ready = open && gnt[1];
    assign arb_update = open && (gnt != 2'b00);
    assign next_hold  = gnt[1] ? src1_data : src0_data;
`endif

    assign accept = src0_ready || src1_ready;

    assign audio_mclk = cnt[MCLK_BIT];
    assign audio_sck  = cnt[SCK_BIT];
    assign audio_lrck = cnt[LRCK_BIT];
    assign audio_sdin = sr[31];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            hold_full    <= 1'b0;
            hold         <= '0;
            sr           <= '0;
            last_tx      <= '0;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            cnt         <= cnt + 1'b1;
            frame_start <= boundary;
            underrun    <= 1'b0;
            if (boundary) begin
                if (hold_full) begin
                    sr        <= hold;
                    last_tx   <= hold;
                    hold_full <= 1'b0;
                end else begin
                    // Disabled scheduler always sends silence, even in repeat mode.
                    sr <= (UNDERRUN_HOLD && en) ? last_tx : '0;
                    if (en) begin
                        underrun <= 1'b1;
                        if (underrun_cnt != 16'hFFFF)
                            underrun_cnt <= underrun_cnt + 1'b1;
                    end
                end
            end else begin
                if (shift_pos)
                    sr <= {sr[30:0], 1'b0};
                if (accept) begin
                    hold      <= next_hold;
                    hold_full <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/i2s_sample_scheduler.md
# i2s_sample_scheduler

Frame scheduler for the on-board I2S audio DAC path. It derives the MCLK, LRCK and SCK waveforms from the single system clock and accepts 32-bit stereo samples from two requesters over valid/ready handshakes. It holds at most one sample per frame and serializes it MSB-first on the data pin, so two sample sources share one DAC.

## Interface
- `RR_EN_DEFAULT`, 1: arbitration mode after reset. 1 = round-robin, 0 = fixed priority to src0.
- `UNDERRUN_HOLD`, 0: on underrun, 0 = transmit all-zero frame, 1 = repeat last transmitted sample.
- `clk` input 1: system clock, 100 MHz. Sole clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: scheduler enable. Low = no new samples accepted, zero frames transmitted.
- `src0_valid`, `src1_valid` input 1: requester has a sample.
- `src0_data`, `src1_data` input 32: sample; [31:16] left, [15:0] right, signed two's complement.
- `src0_ready`, `src1_ready` output 1: sample accepted when valid && ready on a rising edge.
- `audio_mclk` output 1: clk/4 (25 MHz).
- `audio_sck` output 1: clk/16 (6.25 MHz).
- `audio_lrck` output 1: clk/512. Low = left half, high = right half.
- `audio_sdin` output 1: serial data, MSB first.
- `frame_start` output 1: one-cycle pulse on the first cycle of each frame.
- `underrun` output 1: one-cycle pulse when a frame starts with no held sample while `en`=1.
- `underrun_cnt` output 16: saturating underrun count.

## Operation
- Free-running 9-bit counter `cnt`, 0..511, wraps. `audio_mclk`=cnt[1], `audio_sck`=cnt[3], `audio_lrck`=cnt[8]; all outputs are registered.
- Holding register `hold` with `hold_full` flag. `srcN_ready` = en && !hold_full && cnt!=511 && grant==N.
- Arbitration applies when both are valid:
  - Round-robin: the grant goes to the source not granted last. `last_grant` resets to 1, so src0 wins the first tie.
  - Fixed priority: src0 always wins the tie.
  - A single valid source is always granted.
  - Only one source is accepted per frame.
- At cnt==511 (frame boundary edge): shift register `sr` loads `hold` if hold_full and clears hold_full. Otherwise `sr` loads 0, or the last loaded value when UNDERRUN_HOLD=1; `underrun` pulses when en=1 and `underrun_cnt` increments, saturating at 16'hFFFF.
- At every other edge where cnt[3:0]==15: `sr` <= {sr[30:0],1'b0}. `audio_sdin`=sr[31], so data changes coincident with each SCK falling edge.
- `en` low: hold still drains at the next boundary; afterwards zero frames are sent and `underrun` is suppressed.

## Timing
- Reset values: cnt=0, hold_full=0, sr=0, last_grant=1, `underrun_cnt`=0. All outputs are 0.
- Latency: a sample accepted anywhere in frame N drives `audio_sdin` from cnt==0 of frame N+1. Bit 31 appears at cnt 0–15 and bit 0 at cnt 496–511.
- `frame_start` is high while cnt==0.
- Ready is forced low at cnt==511, so accept and transfer never coincide.
- `rst` asserted mid-frame: everything returns to reset values on the next edge, discarding any held sample. Serialization restarts with a zero frame.

## Configuration
- `AUDIO_MIX_EN` defined: when both sources are valid in the same cycle and hold is empty, both readies assert and both samples are accepted. hold = per-channel signed 16-bit sum, saturated to 16'h7FFF / 16'h8000. `last_grant` is unchanged. Single-source behaviour is identical to the non-mix build.
- `AUDIO_MIX_EN` undefined: arbitration as described above; no adder logic is present.

## Structure
- Package `audio_sched_pkg`:
  - constants FRAME_LEN=512, SCK_SHIFT_POS=15, MCLK_BIT=1, SCK_BIT=3, LRCK_BIT=8
  - typedef `stereo_sample_t` (packed struct: left[15:0], right[15:0])
  - function `sat_add16`
- Sub-module `rr_arbiter2`: two-request arbiter with mode input and last_grant state. It is the natural split; everything else stays in the top.

## Test plan
- Reset, then idle 2 frames with en=1 → `audio_sdin`=0 throughout, `underrun` pulses at each cnt==511 edge, `underrun_cnt`=2; verify MCLK/SCK/LRCK periods of 4/16/512 clk.
- src0 presents 32'hA5A5_0F0F at cnt 100 → src0_ready high, accepted. The next frame shifts A5A50F0F MSB-first, with each bit held for 16 clk.
- Both valid every cycle, round-robin → frames alternate src0, src1, src0. Fixed priority (RR_EN_DEFAULT=0) → src0 every frame.
- Valid asserted only at cnt==511 → ready low, not accepted. Accepted at cnt==0 and transmitted one frame later.
- `rst` pulsed at cnt==300 with hold full → hold discarded, all outputs 0, `underrun_cnt`=0.
- With `AUDIO_MIX_EN`: src0=32'h7000_8000, src1=32'h2000_F000 simultaneously → transmitted 32'h7FFF_8000, i.e. left saturates positive and right saturates negative.
